// File: rtl/shift_sequencer.sv
// shift_sequencer: iterative barrel shifter (SLL / SRL / SRA).
// One operation at a time. The shift amount is applied as five binary-weighted
// stages of 1, 2, 4, 8 and 16 positions, one stage per clock.
//
// Handshake (valid/ready):
//   - An input transfer happens on a rising edge where in_valid && in_ready.
//   - An output transfer happens on a rising edge where out_valid && out_ready.
//   - in_ready and out_valid are pure functions of the FSM state.
//   - Z and out_valid hold steady until the output transfer.
//
// Timing from the accepting edge (counted as edge 1):
//   - edges 2..6 apply stages 0..4;
//   - edge 6 also loads Z and enters DONE.
// out_valid is therefore high after the 6th edge. With out_ready held high,
// the release edge is the 7th edge and the next accept the 8th, so
// consecutive accepts are 7 cycles apart.
module shift_sequencer #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z,
  output logic             busy
);

  // Operation encodings; 2'b10 is reserved and behaves as SRL.
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b11;

  localparam logic [2:0] K_LAST = 3'(STAGES - 1);

  // FSM state. The enum is kept as a named signal so checkers can bind to it.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Stage counter and captured operands.
  logic [2:0]       k;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] y_q;
  logic             sign_q;
  logic [WIDTH-1:0] work;

  // Combinational datapath.
  logic             accept;
  logic             stage_last;
  logic             release_out;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] stage_res;
  logic             over_range;
  logic [WIDTH-1:0] final_res;

  assign accept      = (state == IDLE)  && in_valid;
  assign stage_last  = (state == SHIFT) && (k == K_LAST);
  assign release_out = (state == DONE)  && out_ready;

  // One stage of the shifter.
  // The stage weight is 2^k. The stage shifts only when the matching captured
  // Y bit is set.
  always_comb begin
    shamt   = 5'd1 << k;
    shifted = work >> shamt;
    case (op_q)
      OP_SLL:  shifted = work << shamt;
      OP_SRA:  shifted = $signed(work) >>> shamt;
      default: shifted = work >> shamt;
    endcase
    stage_res = y_q[k] ? shifted : work;
  end

  // Result value to load into Z.
  // Any set bit in Y[31:5] is an over-range shift; the result is then fully
  // filled with the fill bit. The fill bit is the sign of X for SRA and zero
  // for SLL and SRL.
  always_comb begin
    over_range = |y_q[WIDTH-1:STAGES];
    final_res  = stage_res;
    if (over_range) begin
      final_res = (op_q == OP_SRA) ? {WIDTH{sign_q}} : '0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  // A release edge returns to IDLE only. No accept can happen on that same
  // edge, because in_ready is low while the FSM is in DONE.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (k == K_LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture and stage counter.
  // The captured operands change only on acceptance. Inputs seen in SHIFT or
  // DONE never reach these registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= 2'b00;
      y_q    <= '0;
      sign_q <= 1'b0;
      k      <= 3'd0;
    end else if (accept) begin
      op_q   <= op;
      y_q    <= Y;
      sign_q <= X[WIDTH-1];
      k      <= 3'd0;
    end else if (state == SHIFT) begin
      k <= stage_last ? 3'd0 : k + 3'd1;
    end
  end

  // Working register.
  // It is loaded with X on acceptance and then advances one stage per SHIFT
  // cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work <= '0;
    end else if (accept) begin
      work <= X;
    end else if (state == SHIFT) begin
      work <= stage_res;
    end
  end

  // Output register.
  // Z is loaded only on entry to DONE and otherwise keeps the last result,
  // including after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Z <= '0;
    end else if (stage_last) begin
      Z <= final_res;
    end
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits; only 32 is supported.
REQ-002 Parameter: STAGES, 5, number of shift stages, log2(WIDTH).
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: in_valid  input  1  requester presents an operation.
REQ-006 Port: in_ready  output  1  block can accept an operation.
REQ-007 Port: op  input  2  operation: 00 SLL, 01 SRL, 11 SRA; 10 is reserved and executes as SRL.
REQ-008 Port: X  input  32  operand to be shifted.
REQ-009 Port: Y  input  32  shift amount, unsigned.
REQ-010 Port: out_valid  output  1  Z holds a completed result.
REQ-011 Port: out_ready  input  1  consumer accepts Z.
REQ-012 Port: Z  output  32  result.
REQ-013 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-014 The block SHALL be a three-state FSM:
- IDLE: in_ready=1.
- SHIFT: stage counter k runs 0..4.
- DONE: out_valid=1.
REQ-015 Acceptance:
- The block SHALL capture op, X and Y on a rising edge where in_valid=1 and state is IDLE.
- It SHALL then enter SHIFT with k=0.
REQ-016 Shift stages:
- The block SHALL spend exactly 5 cycles in SHIFT, one stage per cycle.
- Stage k SHALL shift the working register by 2^k positions when captured Y[k]=1, and SHALL leave it unchanged when Y[k]=0.
- After stage 4 the block SHALL enter DONE.
REQ-017 Fill bits SHALL be zero for SLL and SRL, and the captured X[31] for SRA.
REQ-018 Over-range shift:
- Applies when any of captured Y[31:5] is nonzero.
- Result SHALL be 0 for SLL/SRL and {32{X[31]}} for SRA.
- Latency SHALL still be 5 SHIFT cycles.
REQ-019 Latency: out_valid SHALL rise exactly 6 rising edges after the accepting edge, independent of Y.
REQ-020 In DONE, Z and out_valid SHALL stay stable while out_ready=0, with no timeout.
REQ-021 Release:
- On a rising edge in DONE with out_ready=1, the block SHALL return to IDLE.
- out_valid SHALL drop on that edge.
REQ-022 in_ready SHALL be 0 in SHIFT and DONE; in_valid in those states SHALL be ignored and SHALL NOT disturb the captured operands.
REQ-023 A new operation SHALL NOT be accepted on the same edge that releases DONE; the minimum issue interval SHALL be 7 cycles.
REQ-024 Z SHALL retain the last result after release until the next DONE, and SHALL be don't-care-free: it is always a registered value.
REQ-025 Y=0 SHALL produce Z=X after full latency.
REQ-026 Operand and output registers SHALL NOT change except on acceptance, stage updates and entry to DONE.

Reset
REQ-027 While rst_n=0, asynchronously, the block SHALL hold:
- state=IDLE, k=0;
- in_ready=1, out_valid=0, busy=0;
- Z=32'h0 and the working register =0.
REQ-028 Reset asserted in SHIFT or DONE SHALL abort the operation with no result delivered.
REQ-029 After rst_n deassertion, the first rising edge with in_valid=1 SHALL be accepted.

Verification
REQ-030 Basic SRL: op=01, X=32'hFFFFFFFF, Y=1 -> out_valid 6 edges after accept, Z=32'h7FFFFFFF; then repeat for each Y=2,4,8,16 (one bit set at a time) -> Z=32'h3FFFFFFF, 32'h0FFFFFFF, 32'h00FFFFFF, 32'h0000FFFF.
REQ-031 SLL/SRA: op=00, X=1, Y=31 -> Z=32'h80000000; op=11, X=32'h80000000, Y=4 -> Z=32'hF8000000; op=11, X=32'h40000000, Y=6 -> Z=32'h01000000.
REQ-032 Over-range: op=01, X=32'hFFFFFFFF, Y=32 -> Z=0; op=11, X=32'h80000000, Y=40 -> Z=32'hFFFFFFFF; op=00, Y=32'h80000001 -> Z=0.
REQ-033 Backpressure: hold out_ready=0 for 10 cycles in DONE -> Z and out_valid stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-034 Reset mid-op: assert rst_n=0 during SHIFT stage 2 -> immediately out_valid=0, busy=0, Z=0; after release, op=01, X=32'h000000F0, Y=4 -> Z=32'h0000000F.
REQ-035 Back-to-back: two operations with out_ready tied high -> accepts spaced exactly 7 cycles apart, results in order.
